sprite_bitmap_arbiter: RTL and testbench

//  Owns the single-port sprite bitmap RAM and shares it between host byte writes and renderer pixel reads.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_wr_fifo.sv | 57 +++++
 rtl/sprite_bitmap_arbiter.sv | 157 +++++++++++++++
 tb/tb_sprite_bitmap_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite bitmap arbiter: parameter defaults, flush FSM states, RAM grant encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int RAM_BYTES_DEF = 27;
    localparam int ADDR_W_DEF    = 5;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

    // The single RAM port is granted to exactly one owner per cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2,
        GNT_FORCE = 2'd3
    } grant_t;

    function automatic logic grant_is_write(input grant_t g);
        return (g == GNT_WRITE) || (g == GNT_FORCE);
    endfunction

endpackage

// File: rtl/sprite_wr_fifo.sv
// Synchronous FIFO holding queued host bitmap writes as packed {addr, data} entries.
// Latency: pushed entry visible at head_dat the cycle after the push; head_dat is combinational from storage.
// Backpressure: full/empty exposed; push when full and pop when empty are ignored.
// Ports: clk, rst_n; push/push_dat in; pop in; head_dat, count, empty, full out.
module sprite_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sprite_bitmap_arbiter.sv
// Shares the single-port sprite bitmap RAM between queued host byte writes and renderer pixel reads.
// Latency: RAM controls combinational from grant; render_rd_hit/data one cycle after the read request.
// Backpressure: host_wr_ready drops when the queue is full or a flush is draining; renderer is never stalled, only dropped.
// Ports: host write valid/ready channel, renderer read request + hit/data, visible, flush req/done,
//        err_oor, q_level, and the RAM port (en/we/addr/wdata/rdata).
module sprite_bitmap_arbiter
    import sprite_pkg::*;
#(
    parameter int RAM_BYTES  = RAM_BYTES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_wr_valid,
    input  logic [ADDR_W-1:0]           host_wr_addr,
    input  logic [7:0]                  host_wr_data,
    output logic                        host_wr_ready,
    input  logic                        render_rd_valid,
    input  logic [ADDR_W-1:0]           render_rd_addr,
    output logic [7:0]                  render_rd_data,
    output logic                        render_rd_hit,
    input  logic                        visible,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic                        err_oor,
    output logic [$clog2(QDEPTH+1)-1:0] q_level,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [7:0]                  ram_wdata,
    input  logic [7:0]                  ram_rdata
);

    localparam int                SCW     = $clog2(STARVE_MAX+1);
    localparam logic [ADDR_W:0]   RAM_LIM = (ADDR_W+1)'(RAM_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

    arb_state_t state, state_nxt;
    grant_t     grant;
    wr_entry_t  push_ent;
    wr_entry_t  head_ent;
    logic       alive;
    logic [SCW-1:0] starve_cnt;
    logic       q_empty;
    logic       q_full;
    logic       accept;
    logic       addr_oor;
    logic       q_push;
    logic       q_pop;
    logic       force_wr;

    // The beam region only feeds diagnostics that sit outside this block.
    logic unused_visible;
    assign unused_visible = visible;

    // alive holds the port quiet (no grants, not ready) until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // ---------------- host accept ----------------
    // Ready uses pre-pop occupancy: a full queue refuses even when it pops this cycle.
    assign host_wr_ready = alive && (state == RUN) && !q_full;
    assign accept        = host_wr_valid && host_wr_ready;
    assign addr_oor      = ({1'b0, host_wr_addr} >= RAM_LIM);
    assign q_push        = accept && !addr_oor;
    assign push_ent      = '{addr: host_wr_addr, data: host_wr_data};

    sprite_wr_fifo #(
        .DEPTH (QDEPTH),
        .W     ($bits(wr_entry_t))
    ) u_wr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (q_push),
        .push_dat (push_ent),
        .pop      (q_pop),
        .head_dat (head_ent),
        .count    (q_level),
        .empty    (q_empty),
        .full     (q_full)
    );

    // ---------------- grant ----------------
    assign force_wr = (starve_cnt == SCW'(STARVE_MAX)) && !q_empty;

    always_comb begin
        grant = GNT_NONE;
        if (alive) begin
            if (force_wr)             grant = GNT_FORCE;
            else if (render_rd_valid) grant = GNT_READ;
            else if (!q_empty)        grant = GNT_WRITE;
        end
    end

    assign q_pop     = grant_is_write(grant);
    assign ram_en    = (grant != GNT_NONE);
    assign ram_we    = grant_is_write(grant);
    assign ram_addr  = (grant == GNT_READ) ? render_rd_addr : head_ent.addr;
    assign ram_wdata = head_ent.data;

    // ---------------- starve counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (q_pop || q_empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SCW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end

    // ---------------- flush FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // flush_done is a Moore pulse: the FLUSH cycle in which the registered queue count is zero.
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN: begin
                if (alive && flush_req) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (q_empty) begin
                    flush_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            render_rd_hit <= 1'b0;
            err_oor       <= 1'b0;
        end else begin
            render_rd_hit <= (grant == GNT_READ);
            err_oor       <= accept && addr_oor;
        end
    end

    assign render_rd_data = ram_rdata;

endmodule

// File: tb/tb_sprite_bitmap_arbiter.sv
module tb_sprite_bitmap_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_wr_valid;
    logic [4:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic       host_wr_ready;
    logic       render_rd_valid;
    logic [4:0] render_rd_addr;
    logic [7:0] render_rd_data;
    logic       render_rd_hit;
    logic       visible;
    logic       flush_req;
    logic       flush_done;
    logic       err_oor;
    logic [2:0] q_level;
    logic       ram_en;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sprite_bitmap_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_wr_valid   (host_wr_valid),
        .host_wr_addr    (host_wr_addr),
        .host_wr_data    (host_wr_data),
        .host_wr_ready   (host_wr_ready),
        .render_rd_valid (render_rd_valid),
        .render_rd_addr  (render_rd_addr),
        .render_rd_data  (render_rd_data),
        .render_rd_hit   (render_rd_hit),
        .visible         (visible),
        .flush_req       (flush_req),
        .flush_done      (flush_done),
        .err_oor         (err_oor),
        .q_level         (q_level),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    // Behavioural single-port synchronous RAM.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic       exp_err;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hit"},   render_rd_hit, 0);
        chk({tag, "_fdone"}, flush_done, 0);
        chk({tag, "_err"},   err_oor, 0);
        chk({tag, "_qlvl"},  q_level, 0);
        chk({tag, "_en"},    ram_en, 0);
        chk({tag, "_we"},    ram_we, 0);
        chk({tag, "_rdy"},   host_wr_ready, 0);
    endtask

    initial begin
        int early;
        int wr_seen;

        vecs[0] = '{addr: 5'd5,  data: 8'h3C, exp_err: 1'b0};
        vecs[1] = '{addr: 5'd0,  data: 8'h11, exp_err: 1'b0};
        vecs[2] = '{addr: 5'd26, data: 8'hE5, exp_err: 1'b0};
        vecs[3] = '{addr: 5'd27, data: 8'h77, exp_err: 1'b1};
        vecs[4] = '{addr: 5'd31, data: 8'h99, exp_err: 1'b1};
        vecs[5] = '{addr: 5'd13, data: 8'h5A, exp_err: 1'b0};
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        rst_n = 1'b0;
        host_wr_valid = 0; host_wr_addr = 0; host_wr_data = 0;
        render_rd_valid = 0; render_rd_addr = 0;
        visible = 0; flush_req = 0;
        #1;
        check_all_zero("reset");

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        #1;
        chk("ready_after_release", host_wr_ready, 1);

        // ---- 1: four writes, no reads: consecutive writes at addr 0..3 ----
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i < 4) begin
                host_wr_valid = 1; host_wr_addr = 5'(i); host_wr_data = 8'(8'hA0 + i);
            end else begin
                host_wr_valid = 0;
            end
            visible = 1;
            #1;
            if (i < 4) chk("t1_ready", host_wr_ready, 1);
            chk("t1_we", ram_we, (i >= 1) ? 1 : 0);
            if (i >= 1) begin
                chk("t1_addr", ram_addr, i - 1);
                chk("t1_wdata", ram_wdata, 8'hA0 + i - 1);
            end
        end
        cyc(); #1;
        chk("t1_qlvl_zero", q_level, 0);
        chk("t1_idle_en", ram_en, 0);

        // ---- 2/3: fill queue under constant reads, then forced write ----
        cyc();
        render_rd_valid = 1; render_rd_addr = 5'd1;
        host_wr_valid = 1; host_wr_addr = 5'd0; host_wr_data = 8'hC0;
        #1;
        chk("t2_read_grant", {ram_en, ram_we}, 2'b10);
        early = 0;
        for (int k = 1; k <= 66; k++) begin
            cyc();
            if (k <= 3) begin
                host_wr_valid = 1; host_wr_addr = 5'(k); host_wr_data = 8'(8'hC0 + k);
            end else if (k == 4) begin
                host_wr_valid = 1; host_wr_addr = 5'd9; host_wr_data = 8'hEE;
            end else begin
                host_wr_valid = 0;
            end
            #1;
            if (k == 4) begin
                chk("t2_full_ready", host_wr_ready, 0);
                chk("t2_full_qlvl", q_level, 4);
            end
            if (k < 65 && ram_we) early++;
            if (k == 64) chk("t3_no_early_write", early, 0);
            if (k == 65) begin
                chk("t3_force_we", ram_we, 1);
                chk("t3_force_addr", ram_addr, 0);
                chk("t3_force_data", ram_wdata, 8'hC0);
                chk("t3_prev_hit", render_rd_hit, 1);
                chk("t3_prev_rdata", render_rd_data, 8'hA1);
            end
            if (k == 66) begin
                chk("t3_dropped_hit", render_rd_hit, 0);
                chk("t3_qlvl_after", q_level, 3);
            end
        end
        render_rd_valid = 0;
        repeat (4) cyc();
        #1;
        chk("t3_drained", q_level, 0);

        // ---- table: single write, then readback when in range ----
        for (int v = 0; v < 6; v++) begin
            cyc();
            host_wr_valid = 1; host_wr_addr = vecs[v].addr; host_wr_data = vecs[v].data;
            #1;
            cyc();
            host_wr_valid = 0;
            #1;
            chk("vec_err", err_oor, vecs[v].exp_err);
            if (vecs[v].exp_err) begin
                chk("vec_oor_no_en", ram_en, 0);
                chk("vec_oor_qlvl", q_level, 0);
            end else begin
                chk("vec_we", ram_we, 1);
                chk("vec_addr", ram_addr, vecs[v].addr);
                chk("vec_data", ram_wdata, vecs[v].data);
            end
            cyc();
            if (!vecs[v].exp_err) begin
                render_rd_valid = 1; render_rd_addr = vecs[v].addr;
            end
            #1;
            chk("vec_err_once", err_oor, 0);
            if (!vecs[v].exp_err) begin
                cyc();
                render_rd_valid = 0;
                #1;
                chk("vec_rd_hit", render_rd_hit, 1);
                chk("vec_rd_data", render_rd_data, vecs[v].data);
            end
        end

        // ---- 6: flush with three queued writes ----
        for (int i = 0; i < 3; i++) begin
            cyc();
            render_rd_valid = 1; render_rd_addr = 5'd0;
            host_wr_valid = 1; host_wr_addr = 5'(7 + i); host_wr_data = 8'(8'hD7 + i);
            #1;
        end
        cyc();
        render_rd_valid = 0; host_wr_valid = 0; flush_req = 1;
        #1;
        chk("t6_w1_addr", ram_we ? ram_addr : 5'h1F, 7);
        for (int i = 1; i < 3; i++) begin
            cyc();
            flush_req = 0;
            #1;
            chk("t6_drain_ready", host_wr_ready, 0);
            chk("t6_drain_done", flush_done, 0);
            chk("t6_wn_addr", ram_we ? ram_addr : 5'h1F, 7 + i);
        end
        cyc(); #1;
        chk("t6_done", flush_done, 1);
        chk("t6_done_ready", host_wr_ready, 0);
        chk("t6_done_en", ram_en, 0);
        cyc(); #1;
        chk("t6_done_once", flush_done, 0);
        chk("t6_ready_back", host_wr_ready, 1);

        // ---- flush with empty queue ----
        cyc();
        flush_req = 1;
        #1;
        chk("fe_req_cycle", flush_done, 0);
        cyc();
        flush_req = 0;
        #1;
        chk("fe_done", flush_done, 1);
        cyc(); #1;
        chk("fe_done_once", flush_done, 0);

        // ---- 7: reset with three queued writes ----
        for (int i = 0; i < 3; i++) begin
            cyc();
            render_rd_valid = 1; render_rd_addr = 5'd0;
            host_wr_valid = 1; host_wr_addr = 5'(20 + i); host_wr_data = 8'(8'h40 + i);
            #1;
        end
        cyc();
        host_wr_valid = 0;
        #1;
        chk("t7_queued", q_level, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("t7_rst");
        repeat (2) cyc();
        render_rd_valid = 0;
        rst_n = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (ram_we) wr_seen++;
        end
        chk("t7_no_write", wr_seen, 0);
        chk("t7_qlvl", q_level, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
